// File: rtl/cpu7_csr_access.sv
// rtl/cpu7_csr_access.sv - CSR access sequencer between execute and the CSR file (optional CPU7_CSR_PLV_CHECK_EN)
module cpu7_csr_access #(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
`ifdef CPU7_CSR_PLV_CHECK_EN
  input  logic [1:0]         csr_plv,
`endif
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [CSR_BIT-1:0] req_addr,
  input  logic [GRLEN-1:0]   req_rd_val,
  input  logic [GRLEN-1:0]   req_rj_val,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [GRLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               resp_wen,
  output logic               resp_excp,
  output logic [CSR_BIT-1:0] csr_raddr,
  input  logic [GRLEN-1:0]   csr_rdata,
  output logic [CSR_BIT-1:0] csr_waddr,
  output logic [GRLEN-1:0]   csr_wdata,
  output logic               csr_wen
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_XCHG = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [CSR_BIT-1:0] addr_q;
  logic [GRLEN-1:0]   rd_val_q;
  logic [GRLEN-1:0]   rj_val_q;
  logic [TAG_W-1:0]   tag_q;
  logic [GRLEN-1:0]   old_q;
  logic               excp_q;

  logic               priv_excp;
  logic               accept;
  logic [GRLEN-1:0]   merged;

`ifdef CPU7_CSR_PLV_CHECK_EN
  // Any non-kernel privilege level turns the access into an exception.
  assign priv_excp = (csr_plv != 2'b00);
`else
  assign priv_excp = 1'b0;
`endif

  // A request is taken only when idle and not being flushed away.
  assign accept = (state_q == S_IDLE) & req_valid & ~flush;

  // csrxchg replaces only the bits selected by rj; csrwr replaces everything.
  assign merged = (op_q == OP_XCHG) ? ((old_q & ~rj_val_q) | (rd_val_q & rj_val_q))
                                    : rd_val_q;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and all handshake / CSR port outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_wen   = 1'b0;
    resp_excp  = 1'b0;
    csr_wen    = 1'b0;
    resp_data  = old_q;
    resp_tag   = tag_q;
    csr_raddr  = addr_q;
    csr_waddr  = addr_q;
    csr_wdata  = merged;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if ((req_op == OP_ILL) || priv_excp) begin
            state_d = S_RESP;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = (op_q == OP_RD) ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        // Gating with flush guarantees an aborted instruction never lands.
        csr_wen = ~flush;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_wen   = ~excp_q;
        resp_excp  = excp_q;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Capture the instruction at acceptance and the old CSR value during READ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= OP_RD;
      addr_q   <= '0;
      rd_val_q <= '0;
      rj_val_q <= '0;
      tag_q    <= '0;
      old_q    <= '0;
      excp_q   <= 1'b0;
    end else if (accept) begin
      op_q     <= req_op;
      addr_q   <= req_addr;
      rd_val_q <= req_rd_val;
      rj_val_q <= req_rj_val;
      tag_q    <= req_tag;
      old_q    <= '0;
      excp_q   <= (req_op == OP_ILL) | priv_excp;
    end else if (state_q == S_READ) begin
      old_q    <= csr_rdata;
    end
  end

endmodule

// File: tb/tb_cpu7_csr_access.sv
// tb/tb_cpu7_csr_access.sv - self-checking bench for cpu7_csr_access with a transaction-level model
module tb_cpu7_csr_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [13:0] req_addr;
  logic [31:0] req_rd_val;
  logic [31:0] req_rj_val;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_wen;
  logic        resp_excp;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [1:0]  csr_plv;

  logic [31:0] env_mem [4];
  logic [31:0] ref_mem [4];

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // transaction-level model
  bit          m_busy = 0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [1:0]  m_op;
  logic [13:0] m_addr;
  logic [4:0]  m_tag;
  logic        m_excp;
  logic [31:0] m_old;
  logic [31:0] m_new;

  int          wen_count = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_resp_data = '0;
  logic [4:0]  last_resp_tag = '0;
  logic        last_resp_wen = 1'b0;
  logic        last_resp_excp = 1'b0;

  cpu7_csr_access dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
`ifdef CPU7_CSR_PLV_CHECK_EN
    .csr_plv    (csr_plv),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_rd_val (req_rd_val),
    .req_rj_val (req_rj_val),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_wen   (resp_wen),
    .resp_excp  (resp_excp),
    .csr_raddr  (csr_raddr),
    .csr_rdata  (csr_rdata),
    .csr_waddr  (csr_waddr),
    .csr_wdata  (csr_wdata),
    .csr_wen    (csr_wen)
  );

  always #5 clk = ~clk;

  // CSR file stand-in: combinational read, write on the clock edge.
  assign csr_rdata = env_mem[csr_raddr[1:0]];
  always @(posedge clk) begin
    if (csr_wen) env_mem[csr_waddr[1:0]] <= csr_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit priv_bad();
`ifdef CPU7_CSR_PLV_CHECK_EN
    return csr_plv != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock using the inputs presented in the ending cycle.
  task automatic model_update();
    if (!resetn) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0;
      end else begin
        if (m_age == 2 && !m_excp && (m_op == 2'b01 || m_op == 2'b10))
          ref_mem[m_addr[1:0]] = m_new;
        if (m_age >= m_lat && resp_ready) m_busy = 0;
        else m_age++;
      end
    end else if (req_valid && !flush) begin
      m_busy = 1;
      m_age  = 1;
      m_op   = req_op;
      m_addr = req_addr;
      m_tag  = req_tag;
      m_excp = (req_op == 2'b11) || priv_bad();
      m_old  = m_excp ? 32'h0 : ref_mem[req_addr[1:0]];
      m_new  = (req_op == 2'b01) ? req_rd_val
                                 : ((m_old & ~req_rj_val) | (req_rd_val & req_rj_val));
      m_lat  = m_excp ? 1 : (req_op == 2'b00 ? 2 : 3);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn && chk_en) begin
      automatic bit exp_v   = m_busy && (m_age >= m_lat);
      automatic bit exp_wen = m_busy && (m_age == 2) && !m_excp &&
                              (m_op == 2'b01 || m_op == 2'b10) && !flush;
      chk("req_ready", req_ready, !m_busy);
      chk("resp_valid", resp_valid, exp_v);
      chk("csr_wen", csr_wen, exp_wen);
      if (m_busy) chk("csr_raddr", csr_raddr, m_addr);
      if (exp_wen) begin
        chk("csr_waddr", csr_waddr, m_addr);
        chk("csr_wdata", csr_wdata, m_new);
      end
      if (exp_v) begin
        chk("resp_data", resp_data, m_old);
        chk("resp_tag", resp_tag, m_tag);
        chk("resp_wen", resp_wen, !m_excp);
        chk("resp_excp", resp_excp, m_excp);
      end
      if (csr_wen) begin
        wen_count++;
        last_wdata = csr_wdata;
      end
      if (resp_valid && resp_ready) begin
        last_resp_data = resp_data;
        last_resp_tag  = resp_tag;
        last_resp_wen  = resp_wen;
        last_resp_excp = resp_excp;
      end
    end
  end

  task automatic run_req(input logic [1:0] op, input logic [13:0] addr, input logic [31:0] rd,
                         input logic [31:0] rj, input logic [4:0] tag, input int hold,
                         input int flush_age);
    int n;
    req_op = op; req_addr = addr; req_rd_val = rd; req_rj_val = rj; req_tag = tag;
    req_valid = 1'b1; resp_ready = 1'b0; flush = 1'b0;
    n = 0;
    while (!m_busy && n < 10) begin step(); n++; end
    req_valid = 1'b0;
    chk("accept_timeout", m_busy, 1'b1);
    n = 0;
    while (m_busy && n < 40) begin
      resp_ready = (m_age >= m_lat + hold);
      flush = (flush_age != 0) && (m_age == flush_age);
      step();
      n++;
    end
    flush = 1'b0; resp_ready = 1'b0;
    chk("resp_timeout", m_busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_wen"}, resp_wen, 1'b0);
    chk({tag, "_resp_excp"}, resp_excp, 1'b0);
    chk({tag, "_csr_wen"}, csr_wen, 1'b0);
    chk({tag, "_resp_data"}, resp_data, 32'h0);
    chk({tag, "_resp_tag"}, resp_tag, 5'h0);
    chk({tag, "_csr_raddr"}, csr_raddr, 14'h0);
    chk({tag, "_csr_waddr"}, csr_waddr, 14'h0);
    chk({tag, "_csr_wdata"}, csr_wdata, 32'h0);
  endtask

  initial begin
    int w0;
    env_mem[0] = 32'h4;  env_mem[1] = 32'h11; env_mem[2] = 32'h22; env_mem[3] = 32'h33;
    ref_mem[0] = 32'h4;  ref_mem[1] = 32'h11; ref_mem[2] = 32'h22; ref_mem[3] = 32'h33;
    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; csr_plv = 2'b00;
    req_op = 2'b00; req_addr = '0; req_rd_val = '0; req_rj_val = '0; req_tag = '0;
    step(); step();
    check_reset_outputs("rst");
    resetn = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk_en = 1;
    step();

    // csrrd of CRMD = 0x4
    w0 = wen_count;
    run_req(2'b00, 14'h0, 32'h0, 32'h0, 5'd5, 0, 0);
    chk("rd_data", last_resp_data, 32'h4);
    chk("rd_tag", last_resp_tag, 5'd5);
    chk("rd_wen", last_resp_wen, 1'b1);
    chk("rd_no_csr_wen", wen_count - w0, 0);

    // csrwr 0 over 0x4, then read back
    w0 = wen_count;
    run_req(2'b01, 14'h0, 32'h0, 32'h0, 5'd6, 0, 0);
    chk("wr_wen_pulses", wen_count - w0, 1);
    chk("wr_wdata", last_wdata, 32'h0);
    chk("wr_old", last_resp_data, 32'h4);
    run_req(2'b00, 14'h0, 32'h0, 32'h0, 5'd7, 0, 0);
    chk("wr_readback", last_resp_data, 32'h0);

    // csrxchg with mask 0x4
    run_req(2'b01, 14'h0, 32'h4, 32'h0, 5'd1, 0, 0);
    run_req(2'b10, 14'h0, 32'h0, 32'h4, 5'd2, 0, 0);
    chk("xchg1_wdata", last_wdata, 32'h0);
    chk("xchg1_old", last_resp_data, 32'h4);
    run_req(2'b01, 14'h0, 32'h4, 32'h0, 5'd1, 0, 0);
    run_req(2'b10, 14'h0, 32'hFFFF_FFFF, 32'h4, 5'd3, 0, 0);
    chk("xchg2_wdata", last_wdata, 32'h4);
    chk("xchg2_old", last_resp_data, 32'h4);

    // writeback stalls for 5 cycles
    run_req(2'b00, 14'h1, 32'h0, 32'h0, 5'd9, 5, 0);
    chk("hold_data", last_resp_data, 32'h11);

    // flush while the write is being issued
    w0 = wen_count;
    run_req(2'b01, 14'h1, 32'hDEAD, 32'h0, 5'd4, 0, 2);
    chk("flush_no_wen", wen_count - w0, 0);
    chk("flush_ready", req_ready, 1'b1);
    chk("flush_mem", env_mem[1], 32'h11);

    // illegal op
    run_req(2'b11, 14'h2, 32'h5, 32'h5, 5'd8, 0, 0);
    chk("ill_excp", last_resp_excp, 1'b1);
    chk("ill_wen", last_resp_wen, 1'b0);
    chk("ill_data", last_resp_data, 32'h0);

`ifdef CPU7_CSR_PLV_CHECK_EN
    csr_plv = 2'd3;
    w0 = wen_count;
    run_req(2'b01, 14'h3, 32'h77, 32'h0, 5'd10, 0, 0);
    chk("plv_excp", last_resp_excp, 1'b1);
    chk("plv_no_wen", wen_count - w0, 0);
    csr_plv = 2'd0;
    run_req(2'b00, 14'h3, 32'h0, 32'h0, 5'd11, 0, 0);
    chk("plv0_data", last_resp_data, 32'h33);
`endif

    // reset while the write is pending
    req_op = 2'b01; req_addr = 14'h2; req_rd_val = 32'hABCD; req_tag = 5'd12;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    resetn = 1'b0;
    m_busy = 0;
    #1;
    check_reset_outputs("midrst");
    step(); step();
    resetn = 1'b1;
    step();
    chk("midrst_mem", env_mem[2], 32'h22);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      req_op     = 2'($urandom_range(0, 3));
      req_addr   = 14'($urandom);
      req_rd_val = $urandom;
      req_rj_val = $urandom;
      req_tag    = 5'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
`ifdef CPU7_CSR_PLV_CHECK_EN
      csr_plv    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
`endif
      step();
    end
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    for (int i = 0; i < 4; i++) chk("final_mem", env_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
